// File: rtl/vga_pkg.sv
// vga_pkg
//   Constants and helpers shared by the video-buffer arbiter, its fill engine
//   and the scan-out timing block.
//   - H_CELLS x V_CELLS cell grid, CELLS = total cells
//   - ADDR_W / DATA_W : video buffer address and pixel (RGB332) widths
//   - cell_addr()     : linear cell address from (column, row)
//   - fill_state_e    : fill engine states
package vga_pkg;

    localparam int H_CELLS = 80;
    localparam int V_CELLS = 60;
    localparam int CELLS   = H_CELLS * V_CELLS;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // y*80 + x without a multiplier: 80 = 64 + 16.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x,
                                                    input logic [5:0] y);
        logic [ADDR_W-1:0] xw;
        logic [ADDR_W-1:0] yw;
        xw = ADDR_W'(x);
        yw = ADDR_W'(y);
        return (yw << 6) + (yw << 4) + xw;
    endfunction

endpackage

// File: rtl/vbuf_fill_engine.sv
// vbuf_fill_engine
//   Clear-screen engine: walks every cell address once, writing one colour.
//   The counter only advances in cycles where the arbiter grants it the RAM.
//   Ports:
//     pclk, resetn     clock, async active-low reset
//     start            one-cycle request; ignored while a fill is running
//     color            fill colour, sampled with start
//     grant            this cycle's RAM slot belongs to the fill
//     busy             fill in progress
//     done             one-cycle pulse after the final cell is written
//     addr, color_out  address and colour of the current fill write
module vbuf_fill_engine
    import vga_pkg::*;
(
    input  logic              pclk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] color,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] color_out
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              done_q, done_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    color_d = color;
                end
            end
            FILL: begin
                if (grant) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the values from before this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == FILL);
    assign done      = done_q;
    assign addr      = cnt_q;
    assign color_out = color_q;

endmodule

// File: rtl/vbuf_arbiter.sv
// vbuf_arbiter
//   Owns the single-port video buffer RAM and shares its one access slot per
//   cycle between, in priority order: scan-out reads, a one-entry buffered
//   host write, and the clear-screen fill engine.
//   Ports:
//     pclk, resetn                  pixel clock, async active-low reset
//     disp_req/addr, disp_rdata/rvalid   scan-out read, fixed latency 1
//     wr_valid/ready, wr_x/y/data   host pixel write handshake
//     fill_start/color, fill_busy/done   clear-screen control
//     wr_oob, oob_clr               sticky dropped-write flag and its clear
//     ram_addr/we/wdata, ram_rdata  BRAM port (read data 1-cycle latency)
module vbuf_arbiter
    import vga_pkg::*;
(
    input  logic              pclk,
    input  logic              resetn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [6:0]        wr_x,
    input  logic [5:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              wr_oob,
    input  logic              oob_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              wr_oob_q, wr_oob_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic              grant_fill;
    logic              wr_hs;
    logic              wr_in_range;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_wdata;

    vbuf_fill_engine u_fill (
        .pclk      (pclk),
        .resetn    (resetn),
        .start     (fill_start),
        .color     (fill_color),
        .grant     (grant_fill),
        .busy      (fill_busy),
        .done      (fill_done),
        .addr      (fill_addr),
        .color_out (fill_wdata)
    );

    // Display always wins; a pending write beats the fill so that a write
    // accepted before fill_start lands first and is then painted over.
    assign grant_fill = !disp_req && !pending_q && fill_busy;

    // fill_start blocks the handshake in its own cycle so the fill wins.
    assign wr_ready    = !pending_q && !fill_busy && !fill_start;
    assign wr_hs       = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < 7'(H_CELLS)) && (wr_y < 6'(V_CELLS));

    always_comb begin
        ram_addr  = last_addr_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (pending_q) begin
            ram_addr  = pend_addr_q;
            ram_we    = 1'b1;
            ram_wdata = pend_data_q;
        end else if (fill_busy) begin
            ram_addr  = fill_addr;
            ram_we    = 1'b1;
            ram_wdata = fill_wdata;
        end
        last_addr_d = ram_addr;
    end

    always_comb begin
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wr_oob_d    = wr_oob_q;
        // The buffer issues whenever display leaves the slot free.
        if (pending_q && !disp_req) begin
            pending_d = 1'b0;
        end
        if (wr_hs && wr_in_range) begin
            pending_d   = 1'b1;
            pend_addr_d = cell_addr(wr_x, wr_y);
            pend_data_d = wr_data;
        end
        // An out-of-range write in the same cycle as oob_clr keeps the flag.
        if (wr_hs && !wr_in_range) begin
            wr_oob_d = 1'b1;
        end else if (oob_clr) begin
            wr_oob_d = 1'b0;
        end
        disp_rvalid_d = disp_req;
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            pending_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            wr_oob_q      <= 1'b0;
            disp_rvalid_q <= 1'b0;
            last_addr_q   <= '0;
        end else begin
            pending_q     <= pending_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            wr_oob_q      <= wr_oob_d;
            disp_rvalid_q <= disp_rvalid_d;
            last_addr_q   <= last_addr_d;
        end
    end

    assign disp_rvalid = disp_rvalid_q;
    // The BRAM's output register already holds the word for the cycle that
    // disp_rvalid is high; pass it through, zero otherwise.
    assign disp_rdata  = disp_rvalid_q ? ram_rdata : '0;
    assign wr_oob      = wr_oob_q;

endmodule

// File: tb/tb_vbuf_arbiter.sv
module tb_vbuf_arbiter;
    import vga_pkg::*;

    logic              pclk;
    logic              resetn;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              wr_valid;
    logic              wr_ready;
    logic [6:0]        wr_x;
    logic [5:0]        wr_y;
    logic [DATA_W-1:0] wr_data;
    logic              fill_start;
    logic [DATA_W-1:0] fill_color;
    logic              fill_busy;
    logic              fill_done;
    logic              wr_oob;
    logic              oob_clr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vbuf_arbiter dut (
        .pclk        (pclk),
        .resetn      (resetn),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .fill_start  (fill_start),
        .fill_color  (fill_color),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .wr_oob      (wr_oob),
        .oob_clr     (oob_clr),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return (i == CELLS - 1) ? 8'hE3 : (v[7:0] ^ 8'hA5);
    endfunction

    // BRAM model: read-first, one-cycle read latency.
    logic [DATA_W-1:0] mem [CELLS];
    initial begin
        for (int i = 0; i < CELLS; i++) mem[i] = pat(i);
        forever begin
            @(posedge pclk);
            if (ram_we && ram_addr < ADDR_W'(CELLS)) mem[ram_addr] <= ram_wdata;
            ram_rdata <= (ram_addr < ADDR_W'(CELLS)) ? mem[ram_addr] : '0;
        end
    end

    // Reference contents: mem_ref plus the cells the current fill has painted.
    logic [DATA_W-1:0] mem_ref [CELLS];
    int                filled_gen [CELLS];
    int                cur_gen = 1;
    logic [DATA_W-1:0] fill_col;
    logic              fill_active = 1'b0;
    int                fill_wr_count = 0;
    int                fill_done_count = 0;

    logic [DATA_W-1:0]        exp_rd [$];
    logic [ADDR_W+DATA_W-1:0] exp_wr [$];

    function automatic logic [DATA_W-1:0] exp_cell(input int a);
        return (filled_gen[a] == cur_gen) ? fill_col : mem_ref[a];
    endfunction

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        logic [DATA_W-1:0]        rd;
        logic [ADDR_W+DATA_W-1:0] wr;
        forever begin
            @(negedge pclk);
            if (resetn) begin
                if (disp_req) check("disp_addr_route", 32'(ram_addr), 32'(disp_addr));
                if (disp_rvalid) begin
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", 32'(disp_rvalid), 32'd0);
                    end else begin
                        rd = exp_rd.pop_front();
                        check("rd_data", 32'(disp_rdata), 32'(rd));
                    end
                end
                if (ram_we) begin
                    check("we_in_range", 32'(ram_addr < ADDR_W'(CELLS)), 32'd1);
                    check("we_not_disp", 32'(disp_req), 32'd0);
                    if (exp_wr.size() != 0) begin
                        wr = exp_wr.pop_front();
                        check("host_wr_addr", 32'(ram_addr), 32'(wr[ADDR_W+DATA_W-1:DATA_W]));
                        check("host_wr_data", 32'(ram_wdata), 32'(wr[DATA_W-1:0]));
                    end else if (fill_active && ram_addr < ADDR_W'(CELLS)) begin
                        check("fill_wr_data", 32'(ram_wdata), 32'(fill_col));
                        check("fill_wr_once", 32'(filled_gen[ram_addr] == cur_gen), 32'd0);
                        filled_gen[ram_addr] = cur_gen;
                        fill_wr_count++;
                    end else begin
                        check("wr_unexpected", 32'(ram_we), 32'd0);
                    end
                end
                if (fill_done) fill_done_count++;
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        check("rst_fill_busy",   32'(fill_busy),   32'd0);
        check("rst_fill_done",   32'(fill_done),   32'd0);
        check("rst_wr_oob",      32'(wr_oob),      32'd0);
        check("rst_ram_we",      32'(ram_we),      32'd0);
        check("rst_ram_addr",    32'(ram_addr),    32'd0);
        check("rst_ram_wdata",   32'(ram_wdata),   32'd0);
        check("rst_disp_rdata",  32'(disp_rdata),  32'd0);
    endtask

    // Offers one write; returns one cycle after the handshake edge.
    task automatic host_write(input logic [6:0] x, input logic [5:0] y,
                              input logic [DATA_W-1:0] d, input logic clr,
                              output logic accepted);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_y     = y;
        wr_data  = d;
        oob_clr  = clr;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge pclk);
            if (wr_ready) accepted = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        oob_clr  = 1'b0;
        if (!accepted) check("wr_handshake_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [6:0]        x;
        logic [5:0]        y;
        logic [DATA_W-1:0] d;
        logic              oob;
        logic [ADDR_W-1:0] addr;
    } wr_vec_t;

    wr_vec_t vecs [9];

    initial begin
        logic acc;
        int   w0, d0, cyc;
        logic [ADDR_W-1:0] a;

        vecs[0] = '{7'd79,  6'd59, 8'h1C, 1'b0, 13'd4799};
        vecs[1] = '{7'd0,   6'd0,  8'h11, 1'b0, 13'd0};
        vecs[2] = '{7'd5,   6'd1,  8'h22, 1'b0, 13'd85};
        vecs[3] = '{7'd79,  6'd0,  8'h33, 1'b0, 13'd79};
        vecs[4] = '{7'd0,   6'd59, 8'h44, 1'b0, 13'd4720};
        vecs[5] = '{7'd40,  6'd30, 8'h55, 1'b0, 13'd2440};
        vecs[6] = '{7'd80,  6'd0,  8'h66, 1'b1, 13'd0};
        vecs[7] = '{7'd0,   6'd60, 8'h77, 1'b1, 13'd0};
        vecs[8] = '{7'd127, 6'd63, 8'h88, 1'b1, 13'd0};

        for (int i = 0; i < CELLS; i++) mem_ref[i] = pat(i);

        resetn = 1'b0; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0;
        wr_x = '0; wr_y = '0; wr_data = '0; fill_start = 1'b0;
        fill_color = '0; oob_clr = 1'b0;
        repeat (3) step();
        check_reset_outputs();
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        resetn = 1'b1;
        repeat (2) step();

        // Display read of the last cell.
        disp_req = 1'b1; disp_addr = 13'd4799;
        exp_rd.push_back(exp_cell(4799));
        @(negedge pclk);
        check("disp_no_we", 32'(ram_we), 32'd0);
        step();
        disp_req = 1'b0;
        @(negedge pclk);
        check("disp_rvalid_lat1", 32'(disp_rvalid), 32'd1);
        check("disp_rdata_e3", 32'(disp_rdata), 32'hE3);
        check("disp_no_we2", 32'(ram_we), 32'd0);
        step();

        // Table of host writes, in and out of range.
        foreach (vecs[i]) begin
            if (!vecs[i].oob) begin
                exp_wr.push_back({vecs[i].addr, vecs[i].d});
                mem_ref[vecs[i].addr] = vecs[i].d;
            end
            host_write(vecs[i].x, vecs[i].y, vecs[i].d, 1'b0, acc);
            check("vec_accept", 32'(acc), 32'd1);
            @(negedge pclk);
            check("vec_we",       32'(ram_we),   32'(!vecs[i].oob));
            check("vec_ready_lo", 32'(wr_ready), 32'(vecs[i].oob));
            check("vec_oob",      32'(wr_oob),   32'(vecs[i].oob));
            if (!vecs[i].oob) check("vec_addr", 32'(ram_addr), 32'(vecs[i].addr));
            step();
            @(negedge pclk);
            check("vec_ready_back", 32'(wr_ready), 32'd1);
            check("vec_we_once",    32'(ram_we),   32'd0);
            if (vecs[i].oob) begin
                oob_clr = 1'b1;
                step();
                oob_clr = 1'b0;
                check("vec_oob_clr", 32'(wr_oob), 32'd0);
            end
            step();
        end

        // Out-of-range handshake together with oob_clr: set wins.
        host_write(7'd80, 6'd0, 8'h01, 1'b0, acc);
        check("oob_set", 32'(wr_oob), 32'd1);
        host_write(7'd0, 6'd60, 8'h02, 1'b1, acc);
        check("oob_set_beats_clr", 32'(wr_oob), 32'd1);
        oob_clr = 1'b1;
        step();
        oob_clr = 1'b0;
        check("oob_cleared", 32'(wr_oob), 32'd0);

        // Contention: five display cycles, write offered in the second.
        for (int c = 0; c < 5; c++) begin
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(100 + c * 7);
            exp_rd.push_back(exp_cell(100 + c * 7));
            if (c == 1) begin
                wr_valid = 1'b1; wr_x = 7'd10; wr_y = 6'd2; wr_data = 8'hC3;
                exp_wr.push_back({13'd170, 8'hC3});
                mem_ref[170] = 8'hC3;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge pclk);
            check("cont_no_we", 32'(ram_we), 32'd0);
            if (c == 1) check("cont_ready", 32'(wr_ready), 32'd1);
            if (c >= 2) check("cont_stalled", 32'(wr_ready), 32'd0);
            step();
        end
        disp_req = 1'b0; wr_valid = 1'b0;
        @(negedge pclk);
        check("cont_we_free", 32'(ram_we), 32'd1);
        check("cont_addr", 32'(ram_addr), 32'd170);
        step();
        @(negedge pclk);
        check("cont_we_once", 32'(ram_we), 32'd0);
        step();

        // Full fill, display stealing one slot in eight, fill_start retried.
        fill_col = 8'h00; fill_active = 1'b1;
        w0 = fill_wr_count; d0 = fill_done_count;
        fill_start = 1'b1; fill_color = 8'h00;
        wr_valid = 1'b1; wr_x = 7'd1; wr_y = 6'd1; wr_data = 8'h99;
        @(negedge pclk);
        check("fill_beats_wr", 32'(wr_ready), 32'd0);
        step();
        fill_start = 1'b0; wr_valid = 1'b0;
        check("fill_busy_up", 32'(fill_busy), 32'd1);
        cyc = 0;
        while (fill_busy && cyc < 8000) begin
            if (cyc % 8 == 0) begin
                a = ADDR_W'($urandom_range(CELLS - 1, 0));
                disp_req = 1'b1; disp_addr = a;
                exp_rd.push_back(exp_cell(int'(a)));
            end else begin
                disp_req = 1'b0;
            end
            fill_start = (cyc == 100);
            fill_color = (cyc == 100) ? 8'hFF : 8'h00;
            step();
            cyc++;
        end
        disp_req = 1'b0; fill_start = 1'b0;
        check("fill_timeout", 32'(fill_busy), 32'd0);
        check("fill_done_pulse", 32'(fill_done), 32'd1);
        step();
        check("fill_done_once", 32'(fill_done), 32'd0);
        repeat (4) step();
        check("fill_count", 32'(fill_wr_count - w0), 32'(CELLS));
        check("fill_done_count", 32'(fill_done_count - d0), 32'd1);
        fill_active = 1'b0;
        for (int i = 0; i < CELLS; i++) mem_ref[i] = 8'h00;
        cur_gen++;

        // Pending write held by display across fill_start, then reset mid-fill.
        wr_valid = 1'b1; wr_x = 7'd3; wr_y = 6'd0; wr_data = 8'h77;
        exp_wr.push_back({13'd3, 8'h77});
        @(negedge pclk);
        check("pend_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        disp_req = 1'b1; disp_addr = 13'd50;
        exp_rd.push_back(exp_cell(50));
        fill_col = 8'h5A; fill_active = 1'b1;
        fill_start = 1'b1; fill_color = 8'h5A;
        w0 = fill_wr_count;
        @(negedge pclk);
        check("pend_held", 32'(ram_we), 32'd0);
        step();
        disp_req = 1'b0; fill_start = 1'b0;
        @(negedge pclk);
        check("pend_first_we", 32'(ram_we), 32'd1);
        check("pend_first_addr", 32'(ram_addr), 32'd3);
        check("pend_fill_busy", 32'(fill_busy), 32'd1);
        step();
        cyc = 0;
        while ((fill_wr_count - w0) < 2000 && cyc < 3000) begin
            step();
            cyc++;
        end
        check("fill2_reached_2000", 32'((fill_wr_count - w0) >= 2000), 32'd1);
        d0 = fill_done_count;
        resetn = 1'b0;
        fill_active = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) step();
        resetn = 1'b1;
        @(negedge pclk);
        check("post_rst_busy", 32'(fill_busy), 32'd0);
        check("post_rst_ready", 32'(wr_ready), 32'd1);
        repeat (10) step();
        check("post_rst_no_done", 32'(fill_done_count - d0), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vbuf_arbiter.md
Name: vbuf_arbiter

Overview:
- Owns the single-port 80x60x8 video buffer block RAM and shares it between three users, in fixed priority order:
  1. the scan-out pixel fetch (hard real-time),
  2. a host pixel-write port with a valid/ready handshake,
  3. a clear-screen fill engine that paints every cell with one colour.
- Sits between the VGA timing/scan-out logic and the inferred BRAM, in the pixel clock domain.

Parameters:
- H_CELLS, 80, cells per row.
- V_CELLS, 60, rows.
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= H_CELLS*V_CELLS.
- DATA_W, 8, pixel width (RGB332).

Ports:
- pclk  in  1  pixel clock, 36 MHz from PLL.
- resetn  in  1  asynchronous active-low reset.
- disp_req  in  1  scan-out read request, this cycle.
- disp_addr  in  ADDR_W  scan-out cell address.
- disp_rdata  out  DATA_W  read data.
- disp_rvalid  out  1  disp_rdata valid.
- wr_valid  in  1  host write offered.
- wr_ready  out  1  host write accepted when both high.
- wr_x  in  7  cell column.
- wr_y  in  6  cell row.
- wr_data  in  DATA_W  pixel value.
- fill_start  in  1  one-cycle pulse; start a clear.
- fill_color  in  DATA_W  fill value, sampled with fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse at end of fill.
- wr_oob  out  1  sticky; an out-of-range write was dropped.
- oob_clr  in  1  clears wr_oob.
- ram_addr  out  ADDR_W  BRAM address.
- ram_we  out  1  BRAM write enable.
- ram_wdata  out  DATA_W  BRAM write data.
- ram_rdata  in  DATA_W  BRAM read data, 1-cycle latency.

Behaviour:
- Reset values (async on resetn low, all zero):
  - outputs: disp_rvalid, fill_busy, fill_done, wr_oob, ram_we, ram_addr, ram_wdata, disp_rdata.
  - internal: pending write register, fill counter.
  - state: IDLE.
- Reset mid-fill or with a pending write aborts it silently; fill_done is not pulsed.
- Slot arbitration, once per cycle:
  - disp_req: ram_addr=disp_addr, ram_we=0.
  - else pending host write: issue it, then clear pending.
  - else state FILL: write fill colour at fill counter.
  - else idle: ram_we=0, ram_addr holds its last value.
- ram_addr, ram_we and ram_wdata are combinational from the arbitration.
- Display path:
  - disp_rvalid is disp_req delayed one cycle.
  - disp_rdata is ram_rdata captured in that cycle.
  - Fixed latency 1; display is never stalled.
- Host write path, one-entry buffer:
  - wr_ready = !pending && state!=FILL && !fill_start.
  - On handshake, register addr = wr_y*H_CELLS + wr_x, computed as (y<<6)+(y<<4)+x for the default sizes, zero-extended to ADDR_W.
  - If wr_x>=H_CELLS or wr_y>=V_CELLS: accept the write, do not set pending, set wr_oob.
  - Minimum accept-to-RAM latency is 1 cycle. The write may be delayed indefinitely only by display requests.
- wr_oob:
  - oob_clr clears it.
  - An out-of-range handshake in the same cycle as oob_clr wins (wr_oob=1).
- FSM states IDLE and FILL:
  - IDLE->FILL on fill_start: latch fill_color, counter=0, fill_busy=1.
  - fill_start while in FILL is ignored.
  - In FILL, the counter increments only in cycles where fill wins the slot.
  - FILL->IDLE on the cycle that writes address H_CELLS*V_CELLS-1 (4799). fill_busy drops the next cycle, and fill_done pulses high for that next cycle only.
- Simultaneous events:
  - fill_start together with wr_valid: the fill wins; wr_ready=0 that cycle.
  - A write already pending when the fill starts is issued before the first fill write, so the fill overwrites it.
  - disp_req during FILL steals the slot; the counter holds.
- The block never writes an address >= H_CELLS*V_CELLS.

Decomposition:
- Shared package vga_pkg:
  - constants H_CELLS, V_CELLS, CELLS (4800), ADDR_W, DATA_W;
  - function cell_addr(x,y);
  - FSM state enum {IDLE, FILL}.
- The scan-out timing block also uses cell_addr.
- One natural sub-module, vbuf_fill_engine: counter, colour latch, busy/done, advanced by a grant input.

Test Plan:
- Display read: preload addr 4799=8'hE3, pulse disp_req with addr 4799 -> next cycle disp_rvalid=1, disp_rdata=8'hE3, ram_we=0 throughout.
- Host write: x=79, y=59, data 8'h1C, no display traffic -> ram_addr=4799, ram_we=1, ram_wdata=8'h1C one cycle after handshake; wr_ready low for exactly that cycle.
- Contention: hold disp_req high 5 cycles, then offer a write -> write stalls until disp_req drops and issues on the first free cycle; display reads all return with latency 1.
- Out-of-range: x=80, y=0 -> handshake completes, no ram_we, wr_oob=1; oob_clr -> wr_oob=0.
- Fill: fill_start with colour 8'h00, disp_req 1-in-8 cycles -> exactly 4800 fill writes covering addresses 0..4799 once each; fill_busy falls; a single fill_done pulse.
- Reset mid-fill: deassert resetn at counter 2000 -> all outputs 0 immediately; after release fill_busy=0, no fill_done, wr_ready=1.
